// File: rtl/fll_pkg.sv
// Shared FSM state and decision types plus phase/synchronizer constants for the
// FLL controller and its clk_in-domain gate counter.
package fll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_EVAL
    } fll_state_e;

    typedef enum logic [1:0] {
        DEC_BAND,
        DEC_ABOVE,
        DEC_BELOW
    } fll_dec_e;

    // Length of the CLEAR and SETTLE phases in clk_ref cycles.
    localparam int unsigned PHASE_LEN  = 4;
    // Flops in each clk_ref -> clk_in synchronizer.
    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/fll_ctrl_if.sv
// Configuration and status bundle of the FLL controller; the controller is the
// slave, whoever programs bounds/gate/step and watches the strobe is the master.
interface fll_ctrl_if #(
    parameter int N = 32,
    parameter int M = 8
);
    logic         enable;
    logic [N-1:0] lower_bound;
    logic [N-1:0] upper_bound;
    logic [N-1:0] gate_time;
    logic [M-1:0] step;
    logic [M-1:0] code_init;
    logic [M-1:0] code;
    logic [N-1:0] meas;
    logic         strobe;
    logic         locked;
    logic         sat_hi;
    logic         sat_lo;

    modport master (
        output enable, lower_bound, upper_bound, gate_time, step, code_init,
        input  code, meas, strobe, locked, sat_hi, sat_lo
    );

    modport slave (
        input  enable, lower_bound, upper_bound, gate_time, step, code_init,
        output code, meas, strobe, locked, sat_hi, sat_lo
    );
endinterface

// File: rtl/fll_gate_counter.sv
// clk_in-domain saturating edge counter; clear and gate arrive from clk_ref and
// pass through matching synchronizers so they switch on the same clk_in edge.
module fll_gate_counter
    import fll_pkg::*;
#(
    parameter int N = 32
)
(
    input  logic         clk_in,
    input  logic         reset,
    input  logic         clr,
    input  logic         gate,
    output logic [N-1:0] count
);

    logic [SYNC_DEPTH-1:0] clr_sync;
    logic [SYNC_DEPTH-1:0] gate_sync;

    // Reset release is not synchronized to clk_in: the counter is always
    // cleared by the CLEAR phase before any gate window is counted.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clr_sync  <= '0;
            gate_sync <= '0;
            count     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the old
            // value of its neighbour, which is what makes the shift a synchronizer.
            clr_sync  <= {clr_sync[SYNC_DEPTH-2:0], clr};
            gate_sync <= {gate_sync[SYNC_DEPTH-2:0], gate};
            if (clr_sync[SYNC_DEPTH-1]) begin
                count <= '0;
            end else if (gate_sync[SYNC_DEPTH-1] && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fll_ctrl.sv
// FLL controller: counts clk_in over a clk_ref gate window and steers the code
// into a band. Define FLL_CTRL_SAR_EN to add successive-approximation acquisition.
module fll_ctrl
    import fll_pkg::*;
#(
    parameter int N        = 32,
    parameter int M        = 8,
    parameter int LOCK_CNT = 4
)
(
    input  logic      clk_ref,
    input  logic      reset,
    input  logic      clk_in,
    fll_ctrl_if.slave bus
);

    localparam int            LW         = $clog2(LOCK_CNT + 1);
    localparam logic [N-1:0]  PHASE_LAST = N'(PHASE_LEN - 1);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_CNT);

    fll_state_e    state;
    fll_dec_e      dec;
    logic [N-1:0]  timer;
    logic [N-1:0]  gate_len;
    logic [N-1:0]  count;
    logic [N-1:0]  meas_q;
    logic          clr;
    logic          gate;
    logic          strobe_q;
    logic          loaded;
    logic [M-1:0]  code_q;
    logic [M-1:0]  code_nx;
    logic [M-1:0]  code_up;
    logic [M-1:0]  code_dn;
    logic [M:0]    code_sum;
    logic          sat_hi_q;
    logic          sat_hi_nx;
    logic          sat_lo_q;
    logic          sat_lo_nx;
    logic          locked_q;
    logic          locked_nx;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_nx;

`ifdef FLL_CTRL_SAR_EN
    localparam int PW = (M > 1) ? $clog2(M) : 1;

    logic          sar_active;
    logic          sar_active_nx;
    logic [PW-1:0] bit_ptr;
    logic [PW-1:0] bit_ptr_nx;
`endif

    fll_gate_counter #(.N(N)) u_gate_counter (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (clr),
        .gate   (gate),
        .count  (count)
    );

    assign code_sum = {1'b0, code_q} + {1'b0, bus.step};
    assign code_up  = code_sum[M] ? '1 : code_sum[M-1:0];
    assign code_dn  = (code_q < bus.step) ? '0 : code_q - bus.step;

    // count belongs to clk_in; it is only consumed at the end of SETTLE,
    // when the synchronized gate has long been closed and the value is static.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // fall through and infer a latch.
        dec       = DEC_BAND;
        code_nx   = code_q;
        sat_hi_nx = sat_hi_q;
        sat_lo_nx = sat_lo_q;
        lock_nx   = '0;
        locked_nx = 1'b0;

        // The above-check wins, so an inverted window is never in band.
        if (count > bus.upper_bound) begin
            dec = DEC_ABOVE;
        end else if (count < bus.lower_bound) begin
            dec = DEC_BELOW;
        end

        case (dec)
            DEC_ABOVE: begin
                code_nx   = code_up;
                sat_hi_nx = &code_up;
                sat_lo_nx = 1'b0;
            end
            DEC_BELOW: begin
                code_nx   = code_dn;
                sat_hi_nx = 1'b0;
                sat_lo_nx = ~|code_dn;
            end
            default: begin
                sat_hi_nx = 1'b0;
                sat_lo_nx = 1'b0;
                lock_nx   = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
                locked_nx = (lock_nx == LOCK_MAX);
            end
        endcase

`ifdef FLL_CTRL_SAR_EN
        sar_active_nx = sar_active;
        bit_ptr_nx    = bit_ptr;
        if (sar_active) begin
            // Binary search owns the code; saturation flags are left alone.
            code_nx   = code_q;
            sat_hi_nx = sat_hi_q;
            sat_lo_nx = sat_lo_q;
            if (dec == DEC_BAND) begin
                sar_active_nx = 1'b0;
            end else begin
                if (dec == DEC_BELOW) begin
                    code_nx[bit_ptr] = 1'b0;
                end
                if (bit_ptr == '0) begin
                    sar_active_nx = 1'b0;
                end else begin
                    code_nx[bit_ptr - 1'b1] = 1'b1;
                    bit_ptr_nx              = bit_ptr - 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            gate_len <= N'(1);
            clr      <= 1'b0;
            gate     <= 1'b0;
            strobe_q <= 1'b0;
            loaded   <= 1'b0;
            code_q   <= '0;
            meas_q   <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            locked_q <= 1'b0;
            lock_cnt <= '0;
`ifdef FLL_CTRL_SAR_EN
            sar_active <= 1'b0;
            bit_ptr    <= '0;
`endif
        end else begin
            strobe_q <= 1'b0;
            if (!bus.enable && (state inside {ST_CLEAR, ST_GATE, ST_SETTLE})) begin
                // Abandon the measurement; code and lock status stay as they are.
                state <= ST_IDLE;
                timer <= '0;
                clr   <= 1'b0;
                gate  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.enable) begin
                            state  <= ST_CLEAR;
                            timer  <= '0;
                            clr    <= 1'b1;
                            loaded <= 1'b1;
`ifdef FLL_CTRL_SAR_EN
                            code_q     <= {1'b1, {(M-1){1'b0}}};
                            bit_ptr    <= PW'(M - 1);
                            sar_active <= 1'b1;
`else
                            code_q <= bus.code_init;
`endif
                        end
                    end
                    ST_CLEAR: begin
                        if (timer == PHASE_LAST) begin
                            state    <= ST_GATE;
                            timer    <= '0;
                            clr      <= 1'b0;
                            gate     <= 1'b1;
                            gate_len <= (bus.gate_time == '0) ? N'(1) : bus.gate_time;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_GATE: begin
                        if (timer == gate_len - 1'b1) begin
                            state <= ST_SETTLE;
                            timer <= '0;
                            gate  <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer == PHASE_LAST) begin
                            state    <= ST_EVAL;
                            timer    <= '0;
                            strobe_q <= 1'b1;
                            meas_q   <= count;
                            code_q   <= code_nx;
                            sat_hi_q <= sat_hi_nx;
                            sat_lo_q <= sat_lo_nx;
                            lock_cnt <= lock_nx;
                            locked_q <= locked_nx;
`ifdef FLL_CTRL_SAR_EN
                            sar_active <= sar_active_nx;
                            bit_ptr    <= bit_ptr_nx;
`endif
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_EVAL: begin
                        timer <= '0;
                        if (bus.enable) begin
                            state <= ST_CLEAR;
                            clr   <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: the code register resets to a constant; until the first IDLE exit
    // the output shows code_init directly instead of async-loading a port value.
    assign bus.code   = loaded ? code_q : bus.code_init;
    assign bus.meas   = meas_q;
    assign bus.strobe = strobe_q;
    assign bus.locked = locked_q;
    assign bus.sat_hi = sat_hi_q;
    assign bus.sat_lo = sat_lo_q;

endmodule

// File: tb/tb_fll_ctrl.sv
// Scoreboard bench for fll_ctrl (linear build): clk_in runs at exactly 4x clk_ref,
// so each measurement is 4*max(gate_time,1) and a reference model predicts every strobe.
module tb_fll_ctrl;

    localparam int N        = 32;
    localparam int M        = 8;
    localparam int LOCK     = 4;
    localparam int RATIO    = 4;
    localparam int CODE_MAX = (1 << M) - 1;

    typedef struct {
        int meas;
        int code;
        bit locked;
        bit sat_hi;
        bit sat_lo;
    } exp_t;

    logic clk_ref = 1'b0;
    logic clk_in  = 1'b0;
    logic reset   = 1'b0;

    fll_ctrl_if #(.N(N), .M(M)) bus ();

    fll_ctrl #(.N(N), .M(M), .LOCK_CNT(LOCK)) dut (
        .clk_ref (clk_ref),
        .reset   (reset),
        .clk_in  (clk_in),
        .bus     (bus)
    );

    always #20 clk_ref = ~clk_ref;
    initial begin
        #2;
        forever #5 clk_in = ~clk_in;
    end

    exp_t exp_q[$];
    int   lo_q[$];
    int   hi_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: what the controller should hold after each strobe.
    int m_code;
    int m_lock;
    bit m_locked;
    bit m_sat_hi;
    bit m_sat_lo;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset(input int init);
        m_code   = init;
        m_lock   = 0;
        m_locked = 1'b0;
        m_sat_hi = 1'b0;
        m_sat_lo = 1'b0;
    endtask

    task automatic model_eval(input int meas, input int lo, input int hi, input int step);
        if (meas > hi) begin
            m_code   = (m_code + step > CODE_MAX) ? CODE_MAX : m_code + step;
            m_sat_hi = (m_code == CODE_MAX);
            m_sat_lo = 1'b0;
            m_lock   = 0;
            m_locked = 1'b0;
        end else if (meas < lo) begin
            m_code   = (m_code < step) ? 0 : m_code - step;
            m_sat_lo = (m_code == 0);
            m_sat_hi = 1'b0;
            m_lock   = 0;
            m_locked = 1'b0;
        end else begin
            m_sat_hi = 1'b0;
            m_sat_lo = 1'b0;
            if (m_lock < LOCK) m_lock++;
            m_locked = (m_lock >= LOCK);
        end
    endtask

    task automatic add_b(input int lo, input int hi);
        lo_q.push_back(lo);
        hi_q.push_back(hi);
    endtask

    task automatic rand_bounds(input int meas, output int lo, output int hi);
        case ($urandom_range(0, 4))
            0, 1: begin
                lo = meas - int'($urandom_range(0, 3));
                hi = meas + int'($urandom_range(0, 3));
            end
            2: begin
                hi = meas - 1 - int'($urandom_range(0, 2));
                lo = int'($urandom_range(0, hi));
            end
            3: begin
                lo = meas + 1 + int'($urandom_range(0, 5));
                hi = lo + int'($urandom_range(0, 5));
            end
            default: begin
                lo = meas + int'($urandom_range(1, 5));
                hi = meas - int'($urandom_range(1, 3));
            end
        endcase
    endtask

    // One enable-high run of k measurements; bounds k-1..0 come from lo_q/hi_q.
    task automatic run_meas(input int g, input int k, input int init, input int step);
        int   meas;
        int   got;
        int   budget;
        exp_t e;
        meas          = RATIO * ((g == 0) ? 1 : g);
        bus.gate_time = N'(g);
        bus.code_init = M'(init);
        bus.step      = M'(step);
        m_code        = init;
        for (int i = 0; i < k; i++) begin
            model_eval(meas, lo_q[i], hi_q[i], step);
            e.meas   = meas;
            e.code   = m_code;
            e.locked = m_locked;
            e.sat_hi = m_sat_hi;
            e.sat_lo = m_sat_lo;
            exp_q.push_back(e);
        end
        bus.lower_bound = N'(lo_q[0]);
        bus.upper_bound = N'(hi_q[0]);
        bus.enable      = 1'b1;
        got    = 0;
        budget = k * (g + 20) + 40;
        while (got < k && budget > 0) begin
            @(negedge clk_ref);
            budget--;
            if (bus.strobe) begin
                got++;
                if (got < k) begin
                    bus.lower_bound = N'(lo_q[got]);
                    bus.upper_bound = N'(hi_q[got]);
                end else begin
                    bus.enable = 1'b0;
                end
            end
        end
        if (got < k) begin
            check("strobe_timeout", got, k);
            bus.enable = 1'b0;
            exp_q.delete();
        end
        repeat (4) @(negedge clk_ref);
        check("idle_code", bus.code, m_code);
        check("idle_locked", bus.locked, m_locked);
        lo_q.delete();
        hi_q.delete();
    endtask

    always @(negedge clk_ref) begin : monitor
        exp_t e;
        if (!reset && bus.strobe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("meas", bus.meas, e.meas);
                check("code", bus.code, e.code);
                check("locked", bus.locked, e.locked);
                check("sat_hi", bus.sat_hi, e.sat_hi);
                check("sat_lo", bus.sat_lo, e.sat_lo);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int k;
        int meas;
        int lo;
        int hi;
        int n_strobe;

        bus.enable      = 1'b0;
        bus.lower_bound = '0;
        bus.upper_bound = '0;
        bus.gate_time   = N'(1);
        bus.step        = M'(1);
        bus.code_init   = M'(8'h21);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk_ref);
        check("reset_code", bus.code, 8'h21);
        check("reset_meas", bus.meas, 0);
        check("reset_strobe", bus.strobe, 0);
        check("reset_locked", bus.locked, 0);
        check("reset_sat_hi", bus.sat_hi, 0);
        check("reset_sat_lo", bus.sat_lo, 0);
        model_reset(8'h21);
        reset = 1'b0;
        repeat (2) @(negedge clk_ref);

        // Count 400 inside 395..405: lock after the fourth strobe, code constant.
        for (int i = 0; i < 6; i++) add_b(395, 405);
        run_meas(100, 6, 8'h40, 3);

        // Count 500 above the band: code climbs to the top rail and stays.
        for (int i = 0; i < 3; i++) add_b(395, 405);
        run_meas(125, 3, 250, 10);

        // Count 100 below the band: code hits zero, then an in-band run clears sat_lo.
        for (int i = 0; i < 2; i++) add_b(395, 405);
        run_meas(25, 2, 3, 5);
        add_b(90, 110);
        run_meas(25, 1, 3, 5);

        // Lock, one out-of-band measurement, re-lock.
        for (int i = 0; i < 4; i++) add_b(35, 45);
        add_b(30, 35);
        for (int i = 0; i < 4; i++) add_b(35, 45);
        run_meas(10, 9, 100, 7);

        // gate_time 0 counts as one cycle; inverted window is never in band.
        add_b(4, 4);
        add_b(5, 9);
        run_meas(0, 2, 60, 9);
        add_b(50, 30);
        add_b(45, 44);
        run_meas(10, 2, 120, 6);

        for (int r = 0; r < 8; r++) begin
            g    = int'($urandom_range(0, 30));
            k    = int'($urandom_range(2, 6));
            meas = RATIO * ((g == 0) ? 1 : g);
            for (int i = 0; i < k; i++) begin
                rand_bounds(meas, lo, hi);
                add_b(lo, hi);
            end
            run_meas(g, k, int'($urandom_range(0, CODE_MAX)), int'($urandom_range(0, 40)));
        end

        // Lock, then drop enable mid-SETTLE: no strobe, lock held.
        for (int i = 0; i < 4; i++) add_b(20, 30);
        run_meas(6, 4, 77, 2);
        bus.gate_time = N'(6);
        bus.code_init = M'(90);
        m_code        = 90;
        n_strobe      = 0;
        bus.enable    = 1'b1;
        repeat (13) @(posedge clk_ref);
        @(negedge clk_ref);
        bus.enable = 1'b0;
        repeat (30) begin
            @(negedge clk_ref);
            if (bus.strobe) n_strobe++;
        end
        check("abort_strobes", n_strobe, 0);
        check("abort_code", bus.code, m_code);
        check("abort_locked", bus.locked, m_locked);

        // Reset in the middle of GATE: immediate abort to reset values.
        bus.gate_time   = N'(20);
        bus.code_init   = M'(8'h33);
        bus.lower_bound = '0;
        bus.upper_bound = '0;
        bus.enable      = 1'b1;
        repeat (8) @(posedge clk_ref);
        @(negedge clk_ref);
        reset      = 1'b1;
        bus.enable = 1'b0;
        #1;
        check("midgate_reset_code", bus.code, 8'h33);
        check("midgate_reset_locked", bus.locked, 0);
        check("midgate_reset_meas", bus.meas, 0);
        check("midgate_reset_strobe", bus.strobe, 0);
        model_reset(8'h33);
        repeat (2) @(negedge clk_ref);
        reset    = 1'b0;
        n_strobe = 0;
        repeat (40) begin
            @(negedge clk_ref);
            if (bus.strobe) n_strobe++;
        end
        check("post_reset_strobes", n_strobe, 0);
        check("post_reset_code", bus.code, m_code);

        // First measurement after reset needs a full sequence and uses fresh state.
        add_b(30, 50);
        run_meas(10, 1, 8'h33, 4);

        repeat (5) @(negedge clk_ref);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
